fft_axis_frame_tx: RTL and testbench

// AXI4-Stream master that streams one finished FFT frame out of the result memory to the external AXIS slave.
// A start pulse from the FFT core launches the frame; the block issues sync-read memory addresses,

---
 rtl/fft_axis_frame_tx_if.sv | 13 +
 rtl/fft_axis_frame_tx.sv | 145 ++++++++++++++
 tb/tb_fft_axis_frame_tx.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_axis_frame_tx_if.sv
// AXI4-Stream bundle used on the FFT result output.
// The master drives data, valid and last; the slave drives ready.
interface fft_axis_frame_tx_if #(
    parameter int DATA_WDT = 32
);
    logic [DATA_WDT-1:0] tdata;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/fft_axis_frame_tx.sv
// Streams one finished FFT frame from the sync-read result memory onto an AXIS master.
// A 2-entry skid buffer absorbs the memory read latency and downstream backpressure.
module fft_axis_frame_tx #(
    parameter int DATA_WDT = 32,
    parameter int FFT_LEN  = 1024,
    parameter int ADDR_WDT = $clog2(FFT_LEN),
    parameter int BIT_REV  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                mem_rd_en,
    output logic [ADDR_WDT-1:0] mem_rd_addr,
    input  logic [DATA_WDT-1:0] mem_rd_data,
    fft_axis_frame_tx_if.master m_axis
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [ADDR_WDT-1:0] LAST_IDX = ADDR_WDT'(FFT_LEN - 1);

    state_t              state_q, state_d;
    logic [ADDR_WDT-1:0] rd_idx_q, rd_idx_d;
    logic [ADDR_WDT-1:0] out_idx_q, out_idx_d;
    logic                inflight_q, inflight_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [DATA_WDT-1:0] ent0_q, ent0_d;
    logic [DATA_WDT-1:0] ent1_q, ent1_d;
    logic                done_q, done_d;

    logic                pop;
    logic                rd_en;
    logic [2:0]          occ;
    logic [ADDR_WDT-1:0] rd_addr_rev;

    assign pop = (cnt_q != 2'd0) && m_axis.tready;
    // Credit counts the slot freed by this cycle's pop so the stream runs without bubbles.
    assign occ = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};

    always_comb begin
        state_d  = state_q;
        rd_idx_d = rd_idx_q;
        done_d   = 1'b0;
        rd_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_STREAM;
                    rd_idx_d = '0;
                end
            end
            S_STREAM: begin
                if (occ < 3'd2) begin
                    rd_en    = 1'b1;
                    rd_idx_d = rd_idx_q + ADDR_WDT'(1);
                    if (rd_idx_q == LAST_IDX) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (pop && (out_idx_q == LAST_IDX)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;
        cnt_d      = cnt_q;
        inflight_d = rd_en;
        out_idx_d  = pop ? (out_idx_q + ADDR_WDT'(1)) : out_idx_q;
        case ({inflight_q, pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    ent0_d = mem_rd_data;
                end else begin
                    ent1_d = mem_rd_data;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                ent0_d = ent1_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    ent0_d = mem_rd_data;
                end else begin
                    ent0_d = ent1_q;
                    ent1_d = mem_rd_data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_addr_rev = '0;
        for (int i = 0; i < ADDR_WDT; i++) begin
            rd_addr_rev[i] = rd_idx_q[ADDR_WDT-1-i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_idx_q   <= '0;
            out_idx_q  <= '0;
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_idx_q   <= rd_idx_d;
            out_idx_q  <= out_idx_d;
            inflight_q <= inflight_d;
            cnt_q      <= cnt_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
            done_q     <= done_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign mem_rd_en     = rd_en;
    assign mem_rd_addr   = (BIT_REV != 0) ? rd_addr_rev : rd_idx_q;
    assign m_axis.tvalid = (cnt_q != 2'd0);
    assign m_axis.tdata  = ent0_q;
    assign m_axis.tlast  = (cnt_q != 2'd0) && (out_idx_q == LAST_IDX);

endmodule

// File: tb/tb_fft_axis_frame_tx.sv
// Directed bench for fft_axis_frame_tx with FFT_LEN=8; one natural-order and one bit-reversed instance.
module tb_fft_axis_frame_tx;
    localparam int DW = 32;
    localparam int N  = 8;
    localparam int AW = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tready = 1'b1;

    logic          busy_a, done_a, rd_en_a;
    logic [AW-1:0] rd_addr_a;
    logic [DW-1:0] rd_data_a;
    logic          busy_b, done_b, rd_en_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b;

    fft_axis_frame_tx_if #(.DATA_WDT(DW)) ax_a ();
    fft_axis_frame_tx_if #(.DATA_WDT(DW)) ax_b ();

    assign ax_a.tready = tready;
    assign ax_b.tready = tready;

    fft_axis_frame_tx #(.DATA_WDT(DW), .FFT_LEN(N), .ADDR_WDT(AW), .BIT_REV(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_a), .done(done_a),
        .mem_rd_en(rd_en_a), .mem_rd_addr(rd_addr_a), .mem_rd_data(rd_data_a),
        .m_axis(ax_a.master)
    );

    fft_axis_frame_tx #(.DATA_WDT(DW), .FFT_LEN(N), .ADDR_WDT(AW), .BIT_REV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_b), .done(done_b),
        .mem_rd_en(rd_en_b), .mem_rd_addr(rd_addr_b), .mem_rd_data(rd_data_b),
        .m_axis(ax_b.master)
    );

    always #5 clk = ~clk;

    // Result memory model: mem[i] = 0x100 + i, one cycle read latency.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= 32'h100 + {29'd0, rd_addr_a};
        if (rd_en_b) rd_data_b <= 32'h100 + {29'd0, rd_addr_b};
    end

    int          cyc = 0;
    int          rd_cnt_a = 0;
    int          done_cnt_a = 0;
    int          done_cyc_a = 0;
    int          out_a = 0;
    int          max_out_a = 0;
    int          stall_viol = 0;
    logic        prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic        prev_last = 1'b0;
    int          rd_cyc_q[$];
    logic [DW-1:0] beat_data_q[$];
    logic        beat_last_q[$];
    int          beat_cyc_q[$];
    int          b_addr_q[$];
    logic [DW-1:0] b_data_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_a      <= 0;
            prev_stall <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            if (rd_en_a) begin
                rd_cnt_a <= rd_cnt_a + 1;
                rd_cyc_q.push_back(cyc + 1);
            end
            if (ax_a.tvalid && ax_a.tready) begin
                beat_data_q.push_back(ax_a.tdata);
                beat_last_q.push_back(ax_a.tlast);
                beat_cyc_q.push_back(cyc + 1);
            end
            out_a <= out_a + (rd_en_a ? 1 : 0) - ((ax_a.tvalid && ax_a.tready) ? 1 : 0);
            if (out_a > max_out_a) max_out_a <= out_a;
            if (prev_stall && (!ax_a.tvalid || ax_a.tdata !== prev_data || ax_a.tlast !== prev_last))
                stall_viol <= stall_viol + 1;
            prev_stall <= ax_a.tvalid && !ax_a.tready;
            prev_data  <= ax_a.tdata;
            prev_last  <= ax_a.tlast;
            if (done_a) begin
                done_cnt_a <= done_cnt_a + 1;
                done_cyc_a <= cyc + 1;
            end
        end
    end

    always @(posedge clk) begin
        if (rd_en_b) b_addr_q.push_back(int'(rd_addr_b));
        if (ax_b.tvalid && ax_b.tready) b_data_q.push_back(ax_b.tdata);
    end

    int errors = 0;
    int checks = 0;

    task automatic pulse_start(output int k);
        start = 1'b1;
        k = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt_a >= target) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done_a); end
        checks++; if (rd_en_a !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en_a); end
        checks++; if (rd_addr_a !== 3'd0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr_a); end
        checks++; if (ax_a.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", ax_a.tvalid); end
        checks++; if (ax_a.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", ax_a.tlast); end
        checks++; if (ax_a.tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", ax_a.tdata); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_stream();
        int k, nb, nr, nd;
        bit ok;
        tready = 1'b1;
        nb = beat_data_q.size(); nr = rd_cyc_q.size(); nd = done_cnt_a;
        pulse_start(k);
        wait_done(nd + 1, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL stream_timeout: got no done expected done"); end
        checks++; if (beat_data_q.size() - nb != N) begin errors++; $display("FAIL stream_beats: got %0d expected %0d", beat_data_q.size() - nb, N); end
        checks++; if (rd_cyc_q[nr] != k + 1) begin errors++; $display("FAIL stream_first_rd: got cycle %0d expected %0d", rd_cyc_q[nr], k + 1); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (beat_data_q[nb+i] !== 32'h100 + i)
                begin errors++; $display("FAIL stream_data[%0d]: got %h expected %h", i, beat_data_q[nb+i], 32'h100 + i); end
            checks++;
            if (beat_last_q[nb+i] !== (i == N - 1))
                begin errors++; $display("FAIL stream_last[%0d]: got %b expected %b", i, beat_last_q[nb+i], i == N - 1); end
            checks++;
            if (beat_cyc_q[nb+i] != k + 3 + i)
                begin errors++; $display("FAIL stream_cycle[%0d]: got %0d expected %0d", i, beat_cyc_q[nb+i], k + 3 + i); end
        end
        checks++; if (done_cyc_a != k + N + 3) begin errors++; $display("FAIL stream_done_cycle: got %0d expected %0d", done_cyc_a, k + N + 3); end
        checks++; if (done_cnt_a - nd != 1) begin errors++; $display("FAIL stream_done_count: got %0d expected 1", done_cnt_a - nd); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL stream_busy_end: got %b expected 0", busy_a); end
    endtask

    task automatic test_toggle();
        int k, nb, nr, nd, sv;
        bit ok;
        tready = 1'b1;
        nb = beat_data_q.size(); nr = rd_cnt_a; nd = done_cnt_a; sv = stall_viol;
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (done_cnt_a > nd) begin ok = 1'b1; break; end
            tready = ~tready;
            @(negedge clk);
        end
        tready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL toggle_timeout: got no done expected done"); end
        checks++; if (beat_data_q.size() - nb != N) begin errors++; $display("FAIL toggle_beats: got %0d expected %0d", beat_data_q.size() - nb, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (beat_data_q[nb+i] !== 32'h100 + i || beat_last_q[nb+i] !== (i == N - 1))
                begin errors++; $display("FAIL toggle_beat[%0d]: got %h/%b expected %h/%b", i, beat_data_q[nb+i], beat_last_q[nb+i], 32'h100 + i, i == N - 1); end
        end
        checks++; if (stall_viol != sv) begin errors++; $display("FAIL toggle_stall_stable: got %0d violations expected 0", stall_viol - sv); end
        checks++; if (max_out_a > 2) begin errors++; $display("FAIL toggle_outstanding: got %0d expected <=2", max_out_a); end
        checks++; if (rd_cnt_a - nr != N) begin errors++; $display("FAIL toggle_reads: got %0d expected %0d", rd_cnt_a - nr, N); end
    endtask

    task automatic test_stall();
        int k, nb, nr, nd, bad, sv;
        bit ok;
        nb = beat_data_q.size(); nr = rd_cnt_a; nd = done_cnt_a; sv = stall_viol;
        tready = 1'b0;
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (ax_a.tvalid === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL stall_first_valid: got no tvalid expected tvalid"); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (ax_a.tvalid !== 1'b1 || ax_a.tdata !== 32'h100) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
        checks++; if (rd_cnt_a - nr != 2) begin errors++; $display("FAIL stall_reads: got %0d expected 2", rd_cnt_a - nr); end
        tready = 1'b1;
        wait_done(nd + 1, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: got no done expected done"); end
        checks++; if (beat_data_q.size() - nb != N) begin errors++; $display("FAIL stall_beats: got %0d expected %0d", beat_data_q.size() - nb, N); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (beat_data_q[nb+i] !== 32'h100 + i || beat_last_q[nb+i] !== (i == N - 1)) bad++;
            if (beat_cyc_q[nb+i] != beat_cyc_q[nb] + i) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL stall_release_stream: got %0d bad beats expected 0", bad); end
        checks++; if (stall_viol != sv) begin errors++; $display("FAIL stall_stable: got %0d violations expected 0", stall_viol - sv); end
    endtask

    task automatic test_bitrev();
        int k, na, nd0, nd;
        bit ok;
        int exp_addr[N] = '{0, 4, 2, 6, 1, 5, 3, 7};
        tready = 1'b1;
        na = b_addr_q.size(); nd0 = b_data_q.size(); nd = done_cnt_a;
        pulse_start(k);
        wait_done(nd + 1, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL bitrev_timeout: got no done expected done"); end
        checks++; if (b_data_q.size() - nd0 != N) begin errors++; $display("FAIL bitrev_beats: got %0d expected %0d", b_data_q.size() - nd0, N); end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (b_addr_q[na+i] != exp_addr[i])
                begin errors++; $display("FAIL bitrev_addr[%0d]: got %0d expected %0d", i, b_addr_q[na+i], exp_addr[i]); end
            checks++;
            if (b_data_q[nd0+i] !== 32'h100 + exp_addr[i])
                begin errors++; $display("FAIL bitrev_data[%0d]: got %h expected %h", i, b_data_q[nd0+i], 32'h100 + exp_addr[i]); end
        end
    endtask

    task automatic test_busy_start();
        int k, k2, nb, nr, nd;
        bit ok;
        tready = 1'b1;
        nb = beat_data_q.size(); nr = rd_cnt_a; nd = done_cnt_a;
        pulse_start(k);
        repeat (3) @(negedge clk);
        pulse_start(k2);
        wait_done(nd + 1, ok);
        repeat (6) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL busy_start_timeout: got no done expected done"); end
        checks++; if (beat_data_q.size() - nb != N) begin errors++; $display("FAIL busy_start_beats: got %0d expected %0d", beat_data_q.size() - nb, N); end
        checks++; if (done_cnt_a - nd != 1) begin errors++; $display("FAIL busy_start_dones: got %0d expected 1", done_cnt_a - nd); end
        checks++; if (rd_cnt_a - nr != N) begin errors++; $display("FAIL busy_start_reads: got %0d expected %0d", rd_cnt_a - nr, N); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b expected 0", busy_a); end
    endtask

    task automatic test_back_to_back();
        int k, k2, nb, nd, bad;
        bit ok;
        tready = 1'b1;
        nb = beat_data_q.size(); nd = done_cnt_a;
        k2 = 0;
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (done_a === 1'b1) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL b2b_first_done: got no done expected done"); end
        pulse_start(k2);
        wait_done(nd + 2, ok);
        repeat (3) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: got %0d dones expected 2", done_cnt_a - nd); end
        checks++; if (beat_data_q.size() - nb != 2 * N) begin errors++; $display("FAIL b2b_beats: got %0d expected %0d", beat_data_q.size() - nb, 2 * N); end
        bad = 0;
        for (int i = 0; i < 2 * N; i++) begin
            if (beat_data_q[nb+i] !== 32'h100 + (i % N) || beat_last_q[nb+i] !== ((i % N) == N - 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_data: got %0d bad beats expected 0", bad); end
        checks++; if (beat_cyc_q[nb+N] != k2 + 3) begin errors++; $display("FAIL b2b_second_first_beat: got %0d expected %0d", beat_cyc_q[nb+N], k2 + 3); end
    endtask

    task automatic test_reset_mid();
        int k, nb, nd, bad;
        bit ok;
        tready = 1'b1;
        nb = beat_data_q.size();
        pulse_start(k);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (beat_data_q.size() - nb >= 3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_beat3: got %0d beats expected 3", beat_data_q.size() - nb); end
        checks++; if (ax_a.tdata !== 32'h103) begin errors++; $display("FAIL rstmid_beat3_data: got %h expected 103", ax_a.tdata); end
        rst_n = 1'b0;
        #1;
        checks++; if (ax_a.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b expected 0", ax_a.tvalid); end
        checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b expected 0", busy_a); end
        checks++; if (rd_en_a !== 1'b0 || ax_a.tlast !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en_tlast: got %b/%b expected 0/0", rd_en_a, ax_a.tlast); end
        bad = 0;
        for (int i = nb; i < beat_last_q.size(); i++) if (beat_last_q[i] !== 1'b0) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_no_tlast: got %0d tlast beats expected 0", bad); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        nb = beat_data_q.size(); nd = done_cnt_a;
        pulse_start(k);
        wait_done(nd + 1, ok);
        repeat (2) @(negedge clk);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_restart_timeout: got no done expected done"); end
        checks++; if (beat_data_q.size() - nb != N) begin errors++; $display("FAIL rstmid_restart_beats: got %0d expected %0d", beat_data_q.size() - nb, N); end
        bad = 0;
        for (int i = 0; i < N; i++) begin
            if (beat_data_q[nb+i] !== 32'h100 + i || beat_last_q[nb+i] !== (i == N - 1)) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_restart_data: got %0d bad beats expected 0", bad); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_stall();
        test_bitrev();
        test_busy_start();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
